// File: rtl/clock_timekeeper_if.sv
// rtl/clock_timekeeper_if.sv - control, time and display signal bundle for clock_timekeeper
// Purpose: groups the run/load controls and the time/display outputs of the
//          timekeeper so they travel as one port.
// Signals: run, set_en, set_time[23:0], set_pm       (master -> slave)
//          set_err, hh, mm, ss, pm, sec_pulse,
//          tick_led, an[5:0], seg[6:0]               (slave -> master)
interface clock_timekeeper_if;
    logic        run;
    logic        set_en;
    logic [23:0] set_time;
    logic        set_pm;
    logic        set_err;
    logic [7:0]  hh;
    logic [7:0]  mm;
    logic [7:0]  ss;
    logic        pm;
    logic        sec_pulse;
    logic        tick_led;
    logic [5:0]  an;
    logic [6:0]  seg;

    modport master (
        output run, set_en, set_time, set_pm,
        input  set_err, hh, mm, ss, pm, sec_pulse, tick_led, an, seg
    );

    modport slave (
        input  run, set_en, set_time, set_pm,
        output set_err, hh, mm, ss, pm, sec_pulse, tick_led, an, seg
    );
endinterface

// File: rtl/clock_timekeeper.sv
// rtl/clock_timekeeper.sv - HH:MM:SS BCD timekeeper with load and 6-digit display scan
// Purpose: divides clk to a 1 s tick, keeps BCD time (24h or 12h+pm),
//          accepts validated loads and scans an active-low 7-segment display.
// Ports:   clk - system clock
//          rst - asynchronous active-high reset
//          bus - clock_timekeeper_if.slave (run/load in, time/display out)
module clock_timekeeper #(
    parameter int TICK_DIV   = 50000000,
    parameter int SCAN_DIV   = 50000,
    parameter bit MODE_12H   = 1'b0,
    parameter bit BLANK_LEAD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    clock_timekeeper_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [23:0]   RST_TIME  = MODE_12H ? 24'h120000 : 24'h000000;

    // Digit 0 = ss_lo ... digit 5 = hh_hi: same order as set_time nibbles and scan index.
    logic [5:0][3:0] dig_q, dig_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [SW-1:0]   scan_q, scan_d;
    logic [2:0]      idx_q, idx_d;
    logic            pm_q, pm_d;
    logic            sec_pulse_q, sec_pulse_d;
    logic            set_err_q, set_err_d;
    logic            tick_led_q, tick_led_d;
    logic [5:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            tick;
    logic            load_ok;
    logic            carry;

    function automatic logic time_valid(input logic [23:0] t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        if (t[7:4] > 4'd5 || t[15:12] > 4'd5) ok = 1'b0;
        if (MODE_12H) begin
            if (!((t[23:20] == 4'd0 && t[19:16] != 4'd0) ||
                  (t[23:20] == 4'd1 && t[19:16] <= 4'd2))) ok = 1'b0;
        end else begin
            if (!(t[23:20] < 4'd2 || (t[23:20] == 4'd2 && t[19:16] <= 4'd3))) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign tick    = bus.run && (presc_q == PRESC_MAX);
    assign load_ok = bus.set_en && time_valid(bus.set_time);

    always_comb begin
        presc_d     = presc_q;
        dig_d       = dig_q;
        pm_d        = pm_q;
        sec_pulse_d = 1'b0;
        set_err_d   = 1'b0;
        tick_led_d  = tick_led_q;
        carry       = 1'b1;

        if (bus.run) presc_d = tick ? '0 : presc_q + PW'(1);

        // A valid load wins over a coincident tick and restarts the second.
        if (load_ok) begin
            dig_d   = bus.set_time;
            pm_d    = MODE_12H ? bus.set_pm : 1'b0;
            presc_d = '0;
        end else if (tick) begin
            sec_pulse_d = 1'b1;
            tick_led_d  = ~tick_led_q;
            // Seconds and minutes: odd digits wrap after 5, even after 9.
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (dig_q[i] == ((i % 2 == 1) ? 4'd5 : 4'd9)) begin
                        dig_d[i] = 4'd0;
                    end else begin
                        dig_d[i] = dig_q[i] + 4'd1;
                        carry    = 1'b0;
                    end
                end
            end
            if (carry) begin
                if (MODE_12H) begin
                    if (dig_q[5] == 4'd1 && dig_q[4] == 4'd1) begin
                        dig_d[5] = 4'd1;
                        dig_d[4] = 4'd2;
                        pm_d     = ~pm_q;
                    end else if (dig_q[5] == 4'd1 && dig_q[4] == 4'd2) begin
                        dig_d[5] = 4'd0;
                        dig_d[4] = 4'd1;
                    end else if (dig_q[4] == 4'd9) begin
                        dig_d[5] = dig_q[5] + 4'd1;
                        dig_d[4] = 4'd0;
                    end else begin
                        dig_d[4] = dig_q[4] + 4'd1;
                    end
                end else begin
                    if (dig_q[5] == 4'd2 && dig_q[4] == 4'd3) begin
                        dig_d[5] = 4'd0;
                        dig_d[4] = 4'd0;
                    end else if (dig_q[4] == 4'd9) begin
                        dig_d[5] = dig_q[5] + 4'd1;
                        dig_d[4] = 4'd0;
                    end else begin
                        dig_d[4] = dig_q[4] + 4'd1;
                    end
                end
            end
        end

        if (bus.set_en && !load_ok) set_err_d = 1'b1;
    end

    // an and seg are computed from next-state index and next-state time so both
    // land on the same edge and always describe the same digit.
    always_comb begin
        scan_d = (scan_q == SCAN_MAX) ? '0 : scan_q + SW'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_MAX) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        an_d = ~(6'b000001 << idx_d);
        if (BLANK_LEAD && idx_d == 3'd5 && dig_d[5] == 4'd0) seg_d = 7'b1111111;
        else seg_d = seg_code(dig_d[idx_d]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_q       <= RST_TIME;
            presc_q     <= '0;
            scan_q      <= '0;
            idx_q       <= 3'd0;
            pm_q        <= 1'b0;
            sec_pulse_q <= 1'b0;
            set_err_q   <= 1'b0;
            tick_led_q  <= 1'b0;
            an_q        <= 6'b111110;
            seg_q       <= 7'b1000000;
        end else begin
            dig_q       <= dig_d;
            presc_q     <= presc_d;
            scan_q      <= scan_d;
            idx_q       <= idx_d;
            pm_q        <= pm_d;
            sec_pulse_q <= sec_pulse_d;
            set_err_q   <= set_err_d;
            tick_led_q  <= tick_led_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign bus.hh        = {dig_q[5], dig_q[4]};
    assign bus.mm        = {dig_q[3], dig_q[2]};
    assign bus.ss        = {dig_q[1], dig_q[0]};
    assign bus.pm        = pm_q;
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.set_err   = set_err_q;
    assign bus.tick_led  = tick_led_q;
    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
endmodule

// File: doc/clock_timekeeper.md
Name: clock_timekeeper

Overview:
Parametrised HH:MM:SS timekeeper for the board clock design. It divides the board clock down to a 1 Hz tick and keeps the time in one BCD cascade with correct carries. It supports 24-hour and 12-hour (with PM flag) modes and loads a validated time on request. It also drives a multiplexed, active-low six-digit seven-segment display.

Parameters:
TICK_DIV, 50000000, clk cycles per second tick (>=2)
SCAN_DIV, 50000, clk cycles each display digit stays selected (>=1)
MODE_12H, 0, 0 = 24-hour (00-23), 1 = 12-hour (12,01..11 with pm)
BLANK_LEAD, 0, 1 = blank hh_hi digit when it is 0

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
run  in  1  1 = time advances; 0 = prescaler and time frozen
set_en  in  1  one-cycle load request
set_time  in  24  BCD {hh_hi,hh_lo,mm_hi,mm_lo,ss_hi,ss_lo}, 4 bits each
set_pm  in  1  pm value loaded in 12h mode (ignored in 24h)
set_err  out  1  one-cycle pulse: load rejected
hh  out  8  hours BCD
mm  out  8  minutes BCD
ss  out  8  seconds BCD
pm  out  1  PM flag (always 0 in 24h mode)
sec_pulse  out  1  one-cycle pulse on each second tick
tick_led  out  1  toggles on every tick
an  out  6  digit select, active-low, one-hot
seg  out  7  segments gfedcba, active-low (0 = 1000000, 8 = 0000000, blank = 1111111)

Behaviour:
- Reset (async, rst=1) values:
  - Time = 00:00:00 in 24h mode, or 12:00:00 with pm=0 in 12h mode.
  - prescaler=0, sec_pulse=0, set_err=0, tick_led=0.
  - scan counter=0, digit index=0, an=111110, seg = code of ss_lo.
- Prescaler:
  - Counts 0..TICK_DIV-1 while run=1 and holds while run=0.
  - Tick when it equals TICK_DIV-1 with run=1: prescaler goes to 0, sec_pulse=1 next cycle, tick_led toggles.
  - The time update is visible on the same edge that asserts sec_pulse.
- Cascade on tick:
  - ss_lo 9->0 carries to ss_hi; ss_hi 5->0 carries to mm_lo; minutes behave the same and carry to hours.
  - 24h hours: 23->00.
  - 12h hours: 11->12 toggles pm; 12->01 leaves pm unchanged.
  - 23:59:59 -> 00:00:00 (24h); 11:59:59 pm=1 -> 12:00:00 pm=0 (12h).
- Load (set_en=1):
  - Validity rules:
    - Every nibble <=9, ss_hi<=5, mm_hi<=5.
    - 24h: hours <=23.
    - 12h: hours 01..12.
  - Valid: time and pm take set_time/set_pm on the next edge and the prescaler clears to 0.
  - Invalid: time unchanged, set_err=1 for one cycle, prescaler unaffected.
  - Load has priority over a coincident tick. That tick is discarded (no sec_pulse) and tick_led does not toggle.
  - Load works regardless of run.
- Display scan:
  - Scan counter runs 0..SCAN_DIV-1 continuously, independent of run.
  - At wrap, digit index advances 0..5 and then back to 0.
  - Index order: 0=ss_lo, 1=ss_hi, 2=mm_lo, 3=mm_hi, 4=hh_lo, 5=hh_hi.
  - an bit [index]=0, all other bits 1.
  - seg and an are registered together, so they change on the same edge with no mismatched-digit cycle.
  - Nibble >9 shows blank (unreachable in normal operation).
  - With BLANK_LEAD=1, index 5 with hh_hi=0 shows 1111111.
- Reset mid-count or mid-load: all state returns to reset values immediately; a pending load is dropped.

Test Plan:
1. TICK_DIV=4, run=1 from reset -> sec_pulse high one cycle every 4 clks; after 10 ticks ss=8'h10; tick_led toggles each tick.
2. Load 23:59:58 (24h), 2 ticks -> 23:59:59 then 00:00:00; hh=00, mm=00, ss=00.
3. MODE_12H=1, load 11:59:59 pm=0, 1 tick -> 12:00:00 pm=1; load 12:59:59, 1 tick -> 01:00:00 with pm unchanged.
4. Loads 24:00:00 (24h), 00:10:00 (12h) and 12:60:00 -> set_err one-cycle pulse each; time unchanged.
5. Valid set_en on the same cycle as the tick -> loaded value shown, no sec_pulse, next tick exactly TICK_DIV clks later; run=0 for 20 clks -> no ticks, ss held.
6. SCAN_DIV=2, time 12:34:56 -> an sequence 111110,111101,...,011111 with 2 clks each and seg 6,5,4,3,2,1; assert rst mid-scan -> an=111110 and time reset asynchronously.
